// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the architectural PC and fetches the word at PC
// from instruction memory with a req/ready handshake. It presents the PC/Instr pair
// to the downstream stage. On each accepted advance it loads the next PC from
// PC+4, the branch target or the jump target.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a misaligned
// next PC redirects to TRAP_PC and sets the sticky misaligned flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
   ,parameter logic [31:0] TRAP_PC  = 32'h0000_0080
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCBranch,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] fetch_count
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic        misaligned
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_VALID = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        advance;
    logic        capture;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic [31:0] pc_load;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake qualifiers
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    advance    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_VALID);
    assign imem_addr   = PC;

    // Next-PC select: jump beats branch, branch beats sequential
    always_comb begin
        pc_plus4    = PC + 32'd4;
        jump_target = {pc_plus4[31:28], Instr[25:0], 2'b00};
        if (Jump) begin
            next_pc = jump_target;
        end else if (PCSrc) begin
            next_pc = PCBranch;
        end else begin
            next_pc = pc_plus4;
        end
`ifdef PC_MISALIGN_TRAP_EN
        pc_load = (next_pc[1:0] != 2'b00) ? TRAP_PC : next_pc;
`else
        pc_load = next_pc;
`endif
    end

    // PC, held instruction and advance counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RESET_PC;
            Instr       <= '0;
            fetch_count <= '0;
        end else begin
            if (capture) begin
                Instr <= imem_rdata;
            end
            if (advance) begin
                PC          <= pc_load;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Sticky flag: set on any advance that would load a misaligned PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (advance && (next_pc[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Per-cycle vector table plus hand-written
// sequences for asynchronous reset and long stalls.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] PCBranch;
    logic        PCSrc;
    logic        Jump;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] fetch_count;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misaligned;
    localparam logic [31:0] P_MIS   = 32'h0000_0080;
    localparam logic [31:0] P_AFTER = 32'h0000_0084;
    localparam logic        MIS     = 1'b1;
`else
    localparam logic [31:0] P_MIS   = 32'h0000_0042;
    localparam logic [31:0] P_AFTER = 32'h0000_0046;
    localparam logic        MIS     = 1'b0;
`endif

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCBranch    (PCBranch),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
`ifdef PC_MISALIGN_TRAP_EN
       ,.misaligned  (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        src;
        logic        jmp;
        logic [31:0] br;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic add(input logic rst, input logic rdy, input logic [31:0] rdata,
                       input logic stl, input logic src, input logic jmp,
                       input logic [31:0] br, input logic e_req, input logic [31:0] e_pc,
                       input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_cnt, input logic e_mis);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.src = src;
        v.jmp = jmp; v.br = br; v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_cnt = e_cnt; v.e_mis = e_mis;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_pc,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_cnt, input logic e_mis);
        check({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
        check({tag, ".imem_addr"},   imem_addr,            e_pc);
        check({tag, ".PC"},          PC,                   e_pc);
        check({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
        check({tag, ".Instr"},       Instr,                e_instr);
        check({tag, ".fetch_count"}, fetch_count,          e_cnt);
`ifdef PC_MISALIGN_TRAP_EN
        check({tag, ".misaligned"},  {31'd0, misaligned},  {31'd0, e_mis});
`else
        if (e_mis !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.misaligned: flag expected without feature", tag);
        end
`endif
    endtask

    initial begin
        int unsigned cyc;
        int unsigned req_cycles;
        logic [31:0] pc_hold;

        reset = 1'b1; PCBranch = '0; PCSrc = 1'b0; Jump = 1'b0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;

        //   rst rdy rdata          stl src jmp br              req pc             vld instr          cnt mis
        add(1, 1, 32'h2008_0005, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
        add(0, 1, 32'h2008_0005, 0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0);
        add(0, 1, 32'h2008_0005, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 0, 0);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 1, 0);
        add(0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 1, 0);
        add(0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 1, 0);
        add(0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 1, 0);
        add(0, 1, 32'h0000_1111, 0, 0, 0, 32'h0,         0, 32'h4,         1, 32'h0000_1111, 1, 0);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8,         0, 32'h0000_1111, 2, 0);
        add(0, 1, 32'h1234_5678, 0, 0, 0, 32'h0,         0, 32'h8,         1, 32'h1234_5678, 2, 0);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'hC,         0, 32'h1234_5678, 3, 0);
        add(0, 1, 32'h0000_000A, 0, 0, 0, 32'h0,         0, 32'hC,         1, 32'h0000_000A, 3, 0);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h10,        0, 32'h0000_000A, 4, 0);
        add(0, 1, 32'h0800_0100, 0, 0, 0, 32'h0,         0, 32'h10,        1, 32'h0800_0100, 4, 0);
        add(0, 0, 32'h0,         0, 1, 0, 32'h40,        1, 32'h40,        0, 32'h0800_0100, 5, 0);
        add(0, 1, 32'h0800_0100, 0, 0, 0, 32'h0,         0, 32'h40,        1, 32'h0800_0100, 5, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'h999,   0, 32'h40,        1, 32'h0800_0100, 5, 0);
        add(0, 0, 32'h0,         0, 1, 1, 32'h40,        1, 32'h400,       0, 32'h0800_0100, 6, 0);
        add(0, 1, 32'h0,         0, 0, 0, 32'h0,         0, 32'h400,       1, 32'h0,         6, 0);
        add(0, 0, 32'h0,         0, 1, 0, 32'h42,        1, P_MIS,         0, 32'h0,         7, MIS);
        add(0, 1, 32'h0000_0033, 0, 0, 0, 32'h0,         0, P_MIS,         1, 32'h0000_0033, 7, MIS);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, P_AFTER,       0, 32'h0000_0033, 8, MIS);
        add(1, 1, 32'hCAFE_BABE, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
        add(0, 1, 32'hCAFE_BABE, 0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0);
        add(0, 1, 32'h2008_0005, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 0, 0);
        add(0, 0, 32'h0,         0, 1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h2008_0005, 1, 0);
        add(0, 1, 32'h0000_0013, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0000_0013, 1, 0);
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0000_0013, 2, 0);
        add(0, 1, 32'h0000_0001, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0001, 2, 0);
        add(0, 0, 32'h0,         0, 1, 0, 32'h3000_0010, 1, 32'h3000_0010, 0, 32'h0000_0001, 3, 0);
        add(0, 1, 32'h0C00_0020, 0, 0, 0, 32'h0,         0, 32'h3000_0010, 1, 32'h0C00_0020, 3, 0);
        add(0, 0, 32'h0,         0, 0, 1, 32'h0,         1, 32'h3000_0080, 0, 32'h0C00_0020, 4, 0);

        foreach (vq[i]) begin
            reset = vq[i].rst; imem_ready = vq[i].rdy; imem_rdata = vq[i].rdata;
            stall = vq[i].stl; PCSrc = vq[i].src; Jump = vq[i].jmp; PCBranch = vq[i].br;
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_pc, vq[i].e_valid,
                          vq[i].e_instr, vq[i].e_cnt, vq[i].e_mis);
        end

        // Asynchronous reset asserted between edges while fetching
        PCSrc = 1'b0; Jump = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h5555_AAAA;
        #2 reset = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0; imem_rdata = 32'h2008_0005;
        cyc = 0;
        while (!instr_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_latency", cyc, 32'd2);
        check_outputs("restart", 1'b0, 32'h0, 1'b1, 32'h2008_0005, 32'h0, 1'b0);

        // Long stall in S_VALID: nothing moves, no requests
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h7777_7777;
        pc_hold = PC;
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) req_cycles++;
        end
        check("stall_req_cycles", req_cycles, 32'd0);
        check_outputs("stall_hold", 1'b0, pc_hold, 1'b1, 32'h2008_0005, 32'h0, 1'b0);
        stall = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        check_outputs("stall_release", 1'b1, 32'h4, 1'b0, 32'h2008_0005, 32'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
